// File: rtl/karatsuba_mul_16.sv
// ---------------------------------------------------------------------------
// karatsuba_mul_16
//
// Multi-cycle 16x16 signed multiplier returning the low 16 bits of A*B.
// Serves as the MUL functional unit of the CPU datapath behind a start/done
// handshake.
//
// The low 16 bits of a two's-complement product equal the low 16 bits of
// the unsigned product of the raw bit patterns. The core therefore works on
// unsigned patterns and uses one level of Karatsuba decomposition into
// 8-bit halves. A single 9x9 unsigned multiplier is time-shared across the
// three sub-products, one sub-product per cycle:
//   P0   : z0 = al*bl
//   P2   : z2 = ah*bh
//   P1   : z1 = (al+ah)*(bl+bh) - z2 - z0
//   COMB : result = ((z2<<16) + (z1<<8) + z0)[15:0], done pulse
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-low reset
//   start  in   1   begin operation, accepted only while idle
//   A      in  16   signed multiplicand, latched with start
//   B      in  16   signed multiplier, latched with start
//   result out 16   registered low 16 bits of A*B
//   done   out  1   registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module karatsuba_mul_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] result,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P0   = 3'd1,
        S_P2   = 3'd2,
        S_P1   = 3'd3,
        S_COMB = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] z0_q, z0_d;
    logic [15:0] z2_q, z2_d;
    logic [17:0] z1_q, z1_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;

    logic [8:0]  sa_s;
    logic [8:0]  sb_s;
    logic [8:0]  mul_a_s;
    logic [8:0]  mul_b_s;
    logic [17:0] mul_p_s;
    logic [15:0] full_lo_s;

    // Half sums feeding the middle Karatsuba term; 9 bits hold the carry.
    assign sa_s = {1'b0, a_q[7:0]} + {1'b0, a_q[15:8]};
    assign sb_s = {1'b0, b_q[7:0]} + {1'b0, b_q[15:8]};

    // Operand mux for the single shared 9x9 multiplier.
    always_comb begin
        mul_a_s = 9'd0;
        mul_b_s = 9'd0;
        case (state_q)
            S_P0: begin
                mul_a_s = {1'b0, a_q[7:0]};
                mul_b_s = {1'b0, b_q[7:0]};
            end
            S_P2: begin
                mul_a_s = {1'b0, a_q[15:8]};
                mul_b_s = {1'b0, b_q[15:8]};
            end
            S_P1: begin
                mul_a_s = sa_s;
                mul_b_s = sb_s;
            end
            default: begin
                mul_a_s = 9'd0;
                mul_b_s = 9'd0;
            end
        endcase
    end

    assign mul_p_s = {9'd0, mul_a_s} * {9'd0, mul_b_s};

    // Recombination; bits above 15 are discarded, so z2 cannot affect the
    // result, but the full sum is written out to mirror the decomposition.
    assign full_lo_s = 16'((32'(z2_q) << 16) + (32'(z1_q) << 8) + 32'(z0_q));

    // Next-state and datapath register update logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        z0_d     = z0_q;
        z2_d     = z2_q;
        z1_d     = z1_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = S_P0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_P0: begin
                z0_d    = mul_p_s[15:0];
                state_d = S_P2;
            end
            S_P2: begin
                z2_d    = mul_p_s[15:0];
                state_d = S_P1;
            end
            S_P1: begin
                // Cross term al*bh + ah*bl; never negative, fits in 18 bits.
                z1_d    = mul_p_s - {2'd0, z2_q} - {2'd0, z0_q};
                state_d = S_COMB;
            end
            S_COMB: begin
                result_d = full_lo_s;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            z0_q     <= 16'd0;
            z2_q     <= 16'd0;
            z1_q     <= 18'd0;
            result_q <= 16'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z0_q     <= z0_d;
            z2_q     <= z2_d;
            z1_q     <= z1_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_karatsuba_mul_16.sv
module tb_karatsuba_mul_16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] result;
    logic        done;

    int tests;
    int fails;

    karatsuba_mul_16 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after an edge: present operands, let the next edge
    // (E0) accept them, then scramble the operand inputs.
    task automatic do_start(input string tag, input logic [15:0] a, input logic [15:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 16'($urandom);
        B     = 16'($urandom);
        chk({tag, "_no_stale_done"}, {31'd0, done}, 32'd0);
    endtask

    // Counts edges after E0 until done is seen (bounded); expects 4.
    task automatic wait_done(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        while (n < 12) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, exp});
    endtask

    task automatic done_clears(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int a;
        int b;
        int pulses;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        start = 1'b1;
        A     = 16'd5;
        B     = 16'd5;

        // Reset held with start asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic operation and hold
        do_start("b3x4", 16'd3, 16'd4);
        wait_done("b3x4", 16'h000C);
        done_clears("b3x4");
        repeat (3) @(posedge clk);
        #1;
        chk("b3x4_hold", {16'd0, result}, 32'h000C);

        // Signs
        do_start("m5x7", 16'hFFFB, 16'd7);
        wait_done("m5x7", 16'hFFDD);
        done_clears("m5x7");
        do_start("m5xm7", 16'hFFFB, 16'hFFF9);
        wait_done("m5xm7", 16'h0023);
        done_clears("m5xm7");
        do_start("zero", 16'd0, 16'hFB2E);
        wait_done("zero", 16'h0000);
        done_clears("zero");

        // Truncation
        do_start("t300", 16'd300, 16'd300);
        wait_done("t300", 16'h5F90);
        done_clears("t300");
        do_start("t256", 16'd256, 16'd256);
        wait_done("t256", 16'h0000);
        done_clears("t256");
        do_start("tmin", 16'h8000, 16'hFFFF);
        wait_done("tmin", 16'h8000);
        done_clears("tmin");
        do_start("tmax", 16'h7FFF, 16'h7FFF);
        wait_done("tmax", 16'h0001);
        done_clears("tmax");

        // Start while busy is ignored
        do_start("busy", 16'd1000, 16'd3);
        A     = 16'd7;
        B     = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // one edge already consumed; three more to done
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        chk("busy_done_seen", 32'(pulses), 32'd1);
        chk("busy_result", {16'd0, result}, 32'h0BB8);

        // Back-to-back: start during the done cycle
        do_start("b2b", 16'd11, 16'd13);
        wait_done("b2b_first", 16'h008F);
        do_start("b2b", 16'hFFFE, 16'd21);
        wait_done("b2b_second", 16'hFFD6);
        done_clears("b2b_second");

        // Mid-operation reset
        do_start("mid", 16'h1234, 16'd2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_result", {16'd0, result}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        chk("mid_no_pulse", 32'(pulses), 32'd0);
        chk("mid_result_zero", {16'd0, result}, 32'd0);
        do_start("post_mid", 16'd9, 16'd9);
        wait_done("post_mid", 16'h0051);
        done_clears("post_mid");

        // Sweep against the truncated product
        a = -32678;
        b = -32678;
        while (a < 32678) begin
            do_start("sweep", 16'(a), 16'(b));
            wait_done("sweep", 16'(a * b));
            done_clears("sweep");
            a = a + 411;
            b = b + 281;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
